// File: rtl/spi_e48_pkg.sv
// Shared types, opcodes and the address-to-byte map of the 25AA02E48 model.
package spi_e48_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_READ,
        ST_RDSR,
        ST_IGNORE
    } e48_state_t;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] MAC_BASE = 8'hFA;

    // The EUI-48 occupies the top six bytes, most significant byte at MAC_BASE.
    function automatic logic [7:0] e48_byte(input logic [7:0]  addr,
                                            input logic [47:0] mac,
                                            input logic [7:0]  blank);
        logic [7:0] sel;
        logic [2:0] idx;
        sel = blank;
        idx = 3'(addr - MAC_BASE);
        if (addr >= MAC_BASE) begin
            sel = mac[(5 - int'(idx)) * 8 +: 8];
        end
        return sel;
    endfunction

endpackage

// File: rtl/spi_e48_responder_sync.sv
// Pin synchroniser with a delayed copy for rise/fall detection.
module spi_pin_sync #(
    parameter int unsigned STAGES     = 2,
    parameter logic        IDLE_LEVEL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;
    logic [STAGES:0]   warm;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain <= {STAGES{IDLE_LEVEL}};
            prev  <= IDLE_LEVEL;
            warm  <= '0;
        end else begin
            chain[0] <= pin;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
            prev <= chain[STAGES-1];
            warm <= {warm[STAGES-1:0], 1'b1};
        end
    end

    assign level = chain[STAGES-1];
    // Edges are masked until the chain holds real pin history, so a pin already
    // away from its idle level at reset release does not look like an edge.
    assign rise  = warm[STAGES] &  level & ~prev;
    assign fall  = warm[STAGES] & ~level &  prev;

endmodule

// File: rtl/spi_e48_responder.sv
// SPI mode-0 slave modelling the 25AA02E48 MAC EEPROM (READ and RDSR only),
// oversampling the SPI pins in the clk domain.
module spi_e48_responder #(
    parameter logic [47:0] MAC         = 48'h0004A3_123456,
    parameter logic [7:0]  BLANK       = 8'hFF,
    parameter logic [7:0]  STATUS      = 8'h00,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic spi_clk,
    input  logic e48_csl,
    input  logic e48_hold,
    input  logic spi_mosi,
    output logic spi_miso,
    output logic miso_oe,
    output logic busy,
    output logic cmd_err
);

    import spi_e48_pkg::*;

    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic cs_n, cs_rise, cs_fall;
    logic hold_n, hold_rise_unused, hold_fall_unused;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
        .clk(clk), .reset(reset), .pin(spi_clk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_cs (
        .clk(clk), .reset(reset), .pin(e48_csl),
        .level(cs_n), .rise(cs_rise), .fall(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_hold (
        .clk(clk), .reset(reset), .pin(e48_hold),
        .level(hold_n), .rise(hold_rise_unused), .fall(hold_fall_unused)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_mosi (
        .clk(clk), .reset(reset), .pin(spi_mosi),
        .level(mosi_s), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
    );

    e48_state_t state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] in_sr_q, in_sr_d;
    logic [7:0] out_sr_q, out_sr_d;
    logic [7:0] addr_q, addr_d;
    logic       drive_q, drive_d;
    logic       miso_d, oe_d, err_d;
    logic       qual, q_rise, q_fall;
    logic [7:0] shifted_in, addr_inc;

    // A CS release in the same clk as an SCK edge wins; the edge is dropped.
    assign qual       = ~cs_n & hold_n & ~cs_rise;
    assign q_rise     = sclk_rise & qual;
    assign q_fall     = sclk_fall & qual;
    assign shifted_in = {in_sr_q[6:0], mosi_s};
    assign addr_inc   = addr_q + 8'd1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        in_sr_d   = in_sr_q;
        out_sr_d  = out_sr_q;
        addr_d    = addr_q;
        drive_d   = drive_q;
        miso_d    = spi_miso;
        err_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                    in_sr_d   = '0;
                    drive_d   = 1'b0;
                end
            end
            ST_CMD: begin
                if (q_rise) begin
                    in_sr_d   = shifted_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        if (shifted_in == OP_READ) begin
                            state_d = ST_ADDR;
                        end else if (shifted_in == OP_RDSR) begin
                            state_d  = ST_RDSR;
                            out_sr_d = STATUS;
                        end else begin
                            state_d = ST_IGNORE;
                            err_d   = 1'b1;
                        end
                    end
                end
            end
            ST_ADDR: begin
                if (q_rise) begin
                    in_sr_d   = shifted_in;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        addr_d   = shifted_in;
                        out_sr_d = e48_byte(shifted_in, MAC, BLANK);
                        state_d  = ST_READ;
                    end
                end
            end
            ST_READ, ST_RDSR: begin
                if (q_fall) begin
                    miso_d    = out_sr_q[7];
                    drive_d   = 1'b1;
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    // The next byte is staged right after its predecessor's last bit is driven.
                    if (bit_cnt_q == 3'd7) begin
                        if (state_q == ST_READ) begin
                            addr_d   = addr_inc;
                            out_sr_d = e48_byte(addr_inc, MAC, BLANK);
                        end else begin
                            out_sr_d = STATUS;
                        end
                    end else begin
                        out_sr_d = {out_sr_q[6:0], 1'b0};
                    end
                end
            end
            ST_IGNORE: begin
            end
            default: state_d = ST_IDLE;
        endcase

        if (cs_rise) begin
            state_d = ST_IDLE;
            drive_d = 1'b0;
        end

        oe_d = drive_d & hold_n;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            in_sr_q   <= '0;
            out_sr_q  <= '0;
            addr_q    <= '0;
            drive_q   <= 1'b0;
            spi_miso  <= 1'b0;
            miso_oe   <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            in_sr_q   <= in_sr_d;
            out_sr_q  <= out_sr_d;
            addr_q    <= addr_d;
            drive_q   <= drive_d;
            spi_miso  <= miso_d;
            miso_oe   <= oe_d;
            cmd_err   <= err_d;
        end
    end

    assign busy = (state_q != ST_IDLE) & ~cs_n;

endmodule

// File: tb/tb_spi_e48_responder.sv
// Randomised bench for spi_e48_responder: a scoreboard of expected MISO bytes
// from an EEPROM memory model, drained by a monitor sampling at SCK rises.
module tb_spi_e48_responder;

    logic clk = 1'b0;
    logic reset;
    logic spi_clk, e48_csl, e48_hold, spi_mosi;
    logic spi_miso, miso_oe, busy, cmd_err;

    spi_e48_responder #(
        .MAC(48'h0004A3_123456), .BLANK(8'hFF), .STATUS(8'h00), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .reset(reset), .spi_clk(spi_clk), .e48_csl(e48_csl),
        .e48_hold(e48_hold), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .miso_oe(miso_oe), .busy(busy), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned half  = 5;
    int unsigned err_seen = 0;
    int unsigned exp_err  = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  mem[256];
    logic [7:0]  mac_bytes[6];
    logic [7:0]  mon_byte;
    int unsigned mon_bits = 0;
    logic        err_prev = 1'b0;
    logic [7:0]  op;
    logic [7:0]  exp_b;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        total++;
        if (got !== req) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    task automatic wait_clk(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        wait_clk(half);
        spi_clk = 1'b1;
        wait_clk(half);
        spi_clk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_start();
        half = $urandom_range(5, 7);
        e48_csl = 1'b0;
        wait_clk(4);
    endtask

    task automatic cs_end(input bit check_busy);
        wait_clk(half);
        e48_csl = 1'b1;
        wait_clk(1);
        if (check_busy) check("busy_1clk_after_cs", busy, 1);
        wait_clk(1);
        if (check_busy) check("busy_2clk_after_cs", busy, 0);
        wait_clk(6);
        check("oe_after_cs", miso_oe, 0);
        check("busy_idle", busy, 0);
        check("cmd_err_count", err_seen, exp_err);
    endtask

    task automatic do_read(input logic [7:0] addr, input int unsigned n, input bit check_busy);
        logic [7:0] a;
        a = addr;
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back(mem[a]);
            a = a + 8'd1;
        end
        cs_start();
        send_byte(8'h03);
        send_byte(addr);
        repeat (n * 8) spi_bit(1'($urandom_range(0, 1)));
        cs_end(check_busy);
    endtask

    task automatic do_rdsr(input int unsigned n);
        repeat (n) exp_q.push_back(8'h00);
        cs_start();
        send_byte(8'h05);
        repeat (n * 8) spi_bit(1'($urandom_range(0, 1)));
        cs_end(1'b0);
    endtask

    task automatic do_bad(input logic [7:0] opcode);
        exp_err++;
        cs_start();
        send_byte(opcode);
        repeat (16) begin
            spi_bit(1'($urandom_range(0, 1)));
            check("bad_op_oe", miso_oe, 0);
        end
        cs_end(1'b0);
    endtask

    initial begin
        reset = 1'b1; spi_clk = 1'b0; e48_csl = 1'b1; e48_hold = 1'b1; spi_mosi = 1'b0;
        mac_bytes = '{8'h00, 8'h04, 8'hA3, 8'h12, 8'h34, 8'h56};
        for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
        for (int i = 0; i < 6; i++) mem[250 + i] = mac_bytes[i];

        fork
            forever begin
                @(posedge spi_clk or posedge e48_csl);
                if (e48_csl === 1'b1) begin
                    mon_bits = 0;
                end else if (e48_hold === 1'b1 && reset === 1'b0 && miso_oe === 1'b1) begin
                    mon_byte = {mon_byte[6:0], spi_miso};
                    mon_bits++;
                    if (mon_bits == 8) begin
                        mon_bits = 0;
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_miso_byte got=%02h required=none", mon_byte);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("miso_byte", {24'h0, mon_byte}, {24'h0, exp_b});
                        end
                    end
                end
            end
            forever begin
                @(posedge clk);
                #1;
                if (cmd_err === 1'b1) begin
                    err_seen++;
                    check("cmd_err_single_clk", {31'h0, err_prev}, 0);
                end
                err_prev = cmd_err;
            end
            begin
                #500000;
                total++;
                bad++;
                $display("FAIL watchdog got=timeout required=finish");
                $display("test done: total=%0d bad=%0d", total, bad);
                $finish;
            end
        join_none

        wait_clk(3);
        check("reset_miso", spi_miso, 0);
        check("reset_oe", miso_oe, 0);
        check("reset_busy", busy, 0);
        check("reset_cmd_err", cmd_err, 0);
        reset = 1'b0;
        wait_clk(5);

        do_read(8'hFA, 6, 1'b1);
        do_read(8'hFF, 2, 1'b0);
        do_rdsr(2);
        do_bad(8'hA5);

        // HOLD in the middle of the byte at 0xFB
        exp_q.push_back(mem[8'hFB]);
        cs_start();
        send_byte(8'h03);
        send_byte(8'hFB);
        repeat (3) spi_bit(1'($urandom_range(0, 1)));
        wait_clk(half);
        e48_hold = 1'b0;
        wait_clk(4);
        check("hold_oe_drop", miso_oe, 0);
        repeat (4) begin
            spi_clk = ~spi_clk;
            wait_clk(half);
            check("hold_oe_toggle", miso_oe, 0);
        end
        e48_hold = 1'b1;
        wait_clk(4);
        check("hold_oe_restore", miso_oe, 1);
        repeat (5) spi_bit(1'($urandom_range(0, 1)));
        cs_end(1'b0);

        // CS released after half an address, then a fresh READ
        cs_start();
        send_byte(8'h03);
        repeat (4) spi_bit(1'($urandom_range(0, 1)));
        cs_end(1'b0);
        do_read(8'hFC, 1, 1'b0);

        // reset pulse while a byte is being driven; CS stays low afterwards
        cs_start();
        send_byte(8'h03);
        send_byte(8'hFF);
        spi_bit(1'b0);
        wait_clk(4);
        check("pre_reset_oe", miso_oe, 1);
        check("pre_reset_miso", spi_miso, 1);
        reset = 1'b1;
        wait_clk(1);
        check("mid_reset_miso", spi_miso, 0);
        check("mid_reset_oe", miso_oe, 0);
        check("mid_reset_busy", busy, 0);
        check("mid_reset_cmd_err", cmd_err, 0);
        reset = 1'b0;
        repeat (8) begin
            spi_bit(1'($urandom_range(0, 1)));
            check("post_reset_oe", miso_oe, 0);
        end
        cs_end(1'b0);

        repeat (14) begin
            case ($urandom_range(0, 3))
                0, 1: do_read(($urandom_range(0, 1) != 0) ? 8'($urandom_range(240, 255)) : 8'($urandom),
                              $urandom_range(1, 3), 1'b0);
                2: do_rdsr($urandom_range(1, 2));
                default: begin
                    op = 8'($urandom);
                    if (op == 8'h03 || op == 8'h05) op = 8'hA5;
                    do_bad(op);
                end
            endcase
        end

        check("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_e48_responder.md
Name: spi_e48_responder

Overview:
- SPI mode-0 slave that models the 25AA02E48 MAC EEPROM at the far end of the CPLD's `spi` master.
- Sits in the QeDebug CPLD as a loop-back target, so the master's `oel`, `shiftMode`, `spi_clk`, `e48_csl` and `e48_hold` sequencing can be exercised without the real part.
- Oversamples the SPI pins in the `clk` domain.
- Answers READ (0x03) and RDSR (0x05).

Parameters:
- MAC, 48'h0004A3_123456: EUI-48 returned at addresses 0xFA..0xFF, MSB byte at 0xFA.
- BLANK, 8'hFF: data returned for addresses 0x00..0xF9.
- STATUS, 8'h00: byte returned by RDSR.
- SYNC_STAGES, 2: synchroniser depth on `spi_clk`, `e48_csl`, `e48_hold` and `spi_mosi`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `spi_clk` in 1: SPI clock from the master; idles low (mode 0).
- `e48_csl` in 1: chip select, active low.
- `e48_hold` in 1: hold, active low; pauses the transfer.
- `spi_mosi` in 1: serial data from the master.
- `spi_miso` out 1: serial data to the master.
- `miso_oe` out 1: drive enable for `spi_miso`; high only while shifting a response byte.
- `busy` out 1: high while CS is asserted and the FSM is not IDLE.
- `cmd_err` out 1: one-clk pulse when an unsupported opcode completes.

Behaviour:
- Reset: synchronous, active-high; takes effect on the `clk` edge.
  - Values: state=IDLE, bit counter=0, shift registers=0, `spi_miso`=0, `miso_oe`=0, `busy`=0, `cmd_err`=0.
  - Synchroniser flops reset to their idle levels: `spi_clk`=0, `e48_csl`=1, `e48_hold`=1.
- Synchronisation and edge detection:
  - All four inputs pass through SYNC_STAGES flops.
  - rise/fall are detected on the synchronised `spi_clk` against a one-cycle-delayed copy.
  - Minimum SPI half-period is 4 clk; faster clocking is unsupported.
- Qualified edges:
  - An edge counts only when synchronised CS=0 and HOLD=1.
  - Edges while HOLD=0 are ignored and all state is frozen; `spi_miso` holds its value and `miso_oe` drops to 0.
  - When HOLD returns to 1, `miso_oe` is restored on the next clk.
- Sampling and shifting:
  - MOSI is sampled on a qualified rise, MSB first.
  - MISO changes on a qualified fall, MSB first.
- FSM states: IDLE, CMD, ADDR, READ, RDSR, IGNORE.
  - IDLE -> CMD: on CS falling (synchronised); bit counter cleared.
  - CMD: 8 rises shift in the opcode. On the 8th rise:
    - 0x03 -> ADDR.
    - 0x05 -> RDSR, with STATUS preloaded.
    - anything else -> IGNORE, with a `cmd_err` pulse.
  - ADDR: 8 rises build the address. On the 8th rise the data byte at that address is loaded into the output shifter -> READ.
  - READ, first bit:
    - On the fall following the 8th address rise, `spi_miso` = bit 7 and `miso_oe` = 1.
    - Each later fall shifts the next bit out.
  - READ, byte boundary:
    - After the 8th bit of a byte has been driven, the next fall drives bit 7 of the byte at address+1.
    - The address wraps 0xFF -> 0x00, giving continuous sequential read.
  - RDSR: STATUS is shifted out the same way and repeated indefinitely.
  - IGNORE: `miso_oe` stays 0; waits for CS deassert.
  - Any state -> IDLE on CS rising (synchronised), including mid-byte.
    - `miso_oe` clears on the same clk.
    - Partial bits are discarded; no error is flagged.
- CS glitch shorter than SYNC_STAGES clk: not guaranteed to be seen.
- Reset asserted mid-transfer: outputs take their reset values on the next clk. The block then waits for a fresh CS falling before accepting bits; a transfer already in progress is not resumed.
- Simultaneous CS rise and a qualified edge in the same clk: the CS rise wins and the edge is dropped.
- Data mux:
  - addr >= 0xFA -> MAC byte[addr-0xFA], where 0xFA is MAC[47:40].
  - otherwise -> BLANK.

Decomposition:
- Package `spi_e48_pkg`:
  - state enum.
  - constants OP_READ=8'h03, OP_RDSR=8'h05, MAC_BASE=8'hFA.
  - function `e48_byte(addr, mac, blank)`.
- One sub-module, `spi_pin_sync`: parameterised synchroniser plus rise/fall edge detector for `spi_clk` and CS.
  - Reused for all four pins.
  - Provides the edge pulses and the CS-fall/CS-rise events.

Test Plan:
- READ at 0xFA, 6 bytes:
  - Stimulus: CS low; shift 0x03 then 0xFA; clock 48 bits.
  - Required: MISO = 00 04 A3 12 34 56; `miso_oe`=1 only during those 48 bits; `busy` drops 2 clk after CS high.
- Wrap-around:
  - Stimulus: READ at 0xFF for 2 bytes.
  - Required: MISO = 0x56 then 0xFF (the byte at 0x00).
- RDSR:
  - Stimulus: opcode 0x05; clock 16 bits.
  - Required: MISO = 0x00, 0x00; `cmd_err`=0.
- Bad opcode:
  - Stimulus: opcode 0xA5.
  - Required: a single 1-clk `cmd_err` pulse after the 8th rise; `miso_oe` stays 0 through a further 16 clocks.
- HOLD:
  - Stimulus: READ 0xFB; pull HOLD low after 3 data bits; toggle `spi_clk` 4 times; release HOLD.
  - Required: the toggles are ignored and `miso_oe`=0 during HOLD; the remaining 5 bits complete 0x04.
- Abort and reset:
  - Stimulus: CS high mid-address (after 4 bits), then a new READ at 0xFC.
  - Required: the new READ returns 0xA3.
  - Stimulus: `reset`=1 for 1 clk during a READ.
  - Required: all outputs are 0 on the next clk.
